// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit for the EX stage (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Latency: MUL_LAT+1 cycles for multiplies, WIDTH+1 for divides, 1 for divide-by-zero.
// Backpressure: stallreq holds the pipeline while an operation is in flight; annul aborts it.
module ex_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  input  logic             annul,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             stallreq,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  // Shared datapath: ra is the multiplicand or the dividend/quotient shift
  // register, rb the multiplier or divisor magnitude, rr the partial remainder.
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra, rb, rr;
  logic             mul_signed;
  logic             neg_q, neg_r;
  logic             dz_q;

  // Request decode (annul in IDLE swallows a same-cycle start)
  logic go, go_mul, go_div, go_dz;
  logic is_signed_op;
  logic last;
  logic commit_mul, commit_div;

  assign is_signed_op = ~op[0];
  assign go           = (state == S_IDLE) && start && !annul;
  assign go_mul       = go && !op[1];
  assign go_div       = go && op[1] && (opnd_b != '0);
  assign go_dz        = go && op[1] && (opnd_b == '0);
  assign last         = (cnt == CW'(1));
  assign commit_mul   = (state == S_MUL) && !annul && last;
  assign commit_div   = (state == S_DIV) && !annul && last;

  // Operand magnitudes for signed division; the most negative value maps to
  // itself, which is still the correct unsigned magnitude.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (is_signed_op && opnd_a[WIDTH-1]) ? -opnd_a : opnd_a;
  assign abs_b = (is_signed_op && opnd_b[WIDTH-1]) ? -opnd_b : opnd_b;

  // Full product: sign-extend to 2*WIDTH so a single multiply covers both forms
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  assign ext_a = {{WIDTH{mul_signed & ra[WIDTH-1]}}, ra};
  assign ext_b = {{WIDTH{mul_signed & rb[WIDTH-1]}}, rb};
  assign prod  = ext_a * ext_b;

  // One restoring-division step: shift in the next dividend bit, try to subtract.
  // The partial remainder stays below the divisor, so the difference fits WIDTH bits.
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] sub;
  logic [WIDTH-1:0] rr_n, ra_n;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign shifted = {rr, ra[WIDTH-1]};
  assign ge      = shifted >= {1'b0, rb};
  assign sub     = shifted[WIDTH-1:0] - rb;
  assign rr_n    = ge ? sub : shifted[WIDTH-1:0];
  assign ra_n    = {ra[WIDTH-2:0], ge};
  assign quo_fix = neg_q ? -ra_n : ra_n;
  assign rem_fix = neg_r ? -rr_n : rr_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and status outputs; reset forces all status low
  always_comb begin
    state_nx    = state;
    stallreq    = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      S_IDLE: begin
        stallreq = go;
        if (go_mul)      state_nx = S_MUL;
        else if (go_div) state_nx = S_DIV;
        else if (go_dz)  state_nx = S_DONE;
      end
      S_MUL, S_DIV: begin
        stallreq = 1'b1;
        if (annul)     state_nx = S_IDLE;
        else if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        div_by_zero = dz_q;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (rst) begin
      stallreq    = 1'b0;
      done        = 1'b0;
      div_by_zero = 1'b0;
    end
  end

  // Operand latching, cycle counter and division iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      ra         <= '0;
      rb         <= '0;
      rr         <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go_mul) begin
            ra         <= opnd_a;
            rb         <= opnd_b;
            mul_signed <= is_signed_op;
            cnt        <= CW'(MUL_LAT);
          end else if (go_div) begin
            ra    <= abs_a;
            rb    <= abs_b;
            rr    <= '0;
            neg_q <= is_signed_op & (opnd_a[WIDTH-1] ^ opnd_b[WIDTH-1]);
            neg_r <= is_signed_op & opnd_a[WIDTH-1];
            cnt   <= CW'(WIDTH);
          end
        end
        S_MUL: begin
          cnt <= cnt - CW'(1);
        end
        S_DIV: begin
          ra  <= ra_n;
          rr  <= rr_n;
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Remembers that the pending DONE cycle comes from a zero divisor
  always_ff @(posedge clk) begin
    if (rst) dz_q <= 1'b0;
    else     dz_q <= go_dz;
  end

  // Architectural HI/LO: commits beat software writes, which only land in IDLE/DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (commit_mul) begin
      hi_o <= prod[2*WIDTH-1:WIDTH];
      lo_o <= prod[WIDTH-1:0];
    end else if (commit_div) begin
      hi_o <= rem_fix;
      lo_o <= quo_fix;
    end else if (state == S_IDLE || state == S_DONE) begin
      if (hi_we) hi_o <= wdata;
      if (lo_we) lo_o <= wdata;
    end
  end

endmodule
